dmem_access_ctrl: RTL

// - Initiator side of the data-memory interface. Turns one memory-stage request

---
 rtl/dmem_access_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: one SEQ memory-stage request -> 8 byte xfers.
// Optional DMEM_TIMEOUT_EN aborts a transfer when mem_ack never arrives.
`timescale 1ns/1ps
module dmem_access_ctrl #(
  parameter int MEM_BYTES      = 2048,
  parameter int ADDR_W         = 11,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        icode,
  input  logic [63:0]       valA,
  input  logic [63:0]       valE,
  input  logic [63:0]       valP,
  output logic [63:0]       valM,
  output logic              dmem_error,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [63:0]       data;
    logic              we;
  } req_t;

  localparam logic [63:0] MAX_BASE = 64'(MEM_BYTES - 8);

  state_t      state;
  state_t      state_n;
  req_t        req;
  req_t        dec_req;
  logic [63:0] dec_base;
  logic        dec_mem;
  logic        dec_err;
  logic [2:0]  cnt;
  logic        xfer;
  logic        take;
  logic        last_ack;
  logic        timeout_hit;

`ifdef DMEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_cnt;

  assign timeout_hit = xfer && !mem_ack
                    && (wait_cnt == WAIT_MAX);

  // Consecutive no-ack cycles; cleared by every ack and every new request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (take || (xfer && mem_ack)) begin
      wait_cnt <= '0;
    end else if (xfer && !timeout_hit) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Decode icode into base address, write data and direction
  always_comb begin
    dec_base = '0;
    dec_req  = '0;
    dec_mem  = 1'b0;
    unique case (1'b1)
      (icode == 4'h5): begin
        dec_mem  = 1'b1;
        dec_base = valE;
      end
      (icode == 4'h9),
      (icode == 4'hB): begin
        dec_mem  = 1'b1;
        dec_base = valA;
      end
      (icode == 4'h4),
      (icode == 4'hA): begin
        dec_mem      = 1'b1;
        dec_base     = valE;
        dec_req.data = valA;
        dec_req.we   = 1'b1;
      end
      (icode == 4'h8): begin
        dec_mem      = 1'b1;
        dec_base     = valE;
        dec_req.data = valP;
        dec_req.we   = 1'b1;
      end
      default: ;
    endcase
    dec_req.addr = dec_base[ADDR_W-1:0];
    dec_err      = dec_mem && (dec_base > MAX_BASE);
  end

  assign xfer     = (state == S_XFER);
  assign take     = (state == S_IDLE) && start;
  assign last_ack = xfer && mem_ack && (cnt == 3'd7);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (dec_mem && !dec_err) begin
            state_n = S_XFER;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_XFER: begin
        if (last_ack || timeout_hit) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Request latch and byte counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req <= '0;
      cnt <= '0;
    end else if (take) begin
      req <= dec_req;
      cnt <= '0;
    end else if (xfer && mem_ack) begin
      cnt <= cnt + 3'd1;
    end
  end

  // Read data assembly, little-endian by byte index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valM <= '0;
    end else if (xfer && mem_ack && !req.we) begin
      valM[{cnt, 3'b000} +: 8] <= mem_rdata;
    end
  end

  // Error flag: set by a bad address or a timeout, cleared by next request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_error <= 1'b0;
    end else if (take) begin
      dmem_error <= dec_err;
    end else if (timeout_hit) begin
      dmem_error <= 1'b1;
    end
  end

  assign busy      = xfer;
  assign done      = (state == S_DONE);
  assign mem_req   = xfer;
  assign mem_we    = xfer && req.we;
  assign mem_addr  = xfer ? (req.addr + ADDR_W'(cnt)) : '0;
  assign mem_wdata = (xfer && req.we)
                   ? req.data[{cnt, 3'b000} +: 8] : '0;

endmodule
